cu_seq: RTL

CU_SEQ -- requirements
Module: cu_seq

---
 rtl/cu_seq_if.sv | 47 ++++
 rtl/cu_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cu_seq_if.sv
// Instruction, flag, memory and strobe bundle for the cu_seq control sequencer.
interface cu_seq_if #(
  parameter int OPW  = 6,
  parameter int NREG = 2,
  parameter int IMMW = 9
);
  localparam int RSW = (NREG > 1) ? $clog2(NREG) : 1;

  logic            instr_valid;
  logic            instr_ready;
  logic [OPW-1:0]  opcode;
  logic [RSW-1:0]  ra;
  logic [1:0]      ra_stack;
  logic [IMMW-1:0] imm;
  logic [3:0]      flags;
  logic            mem_ack;
  logic            mem_req;
  logic            mem_we;
  logic            alu_en;
  logic            flag_we;
  logic            mov_en;
  logic            tr_en;
  logic            pc_load;
  logic            sp_inc;
  logic            sp_dec;
  logic [NREG-1:0] reg_sel;
  logic            acc_sel;
  logic            pc_sel;
  logic            busy;
  logic            halted;
  logic            illegal;
  logic            mem_err;

  modport slave (
    input  instr_valid, opcode, ra, ra_stack, imm, flags, mem_ack,
    output instr_ready, mem_req, mem_we, alu_en, flag_we, mov_en, tr_en,
           pc_load, sp_inc, sp_dec, reg_sel, acc_sel, pc_sel,
           busy, halted, illegal, mem_err
  );

  modport master (
    output instr_valid, opcode, ra, ra_stack, imm, flags, mem_ack,
    input  instr_ready, mem_req, mem_we, alu_en, flag_we, mov_en, tr_en,
           pc_load, sp_inc, sp_dec, reg_sel, acc_sel, pc_sel,
           busy, halted, illegal, mem_err
  );
endinterface

// File: rtl/cu_seq.sv
// cu_seq: FETCH/DECODE/EXEC/MEM/WB/HALT control sequencer for a small CPU.
// EXEC strobes are registered on the edge that leaves EXEC, so flags are
// sampled during EXEC and the strobes appear in the following cycle.
// MEM/WB/status outputs are decoded from registered state only.
module cu_seq #(
  parameter int OPW  = 6,
  parameter int NREG = 2,
  parameter int IMMW = 9,
  parameter int TMO  = 15
) (
  input  logic     clk,
  input  logic     rst,
  cu_seq_if.slave  bus
);
  localparam int RSW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int SP1 = (NREG < 2) ? NREG - 1 : 1;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [3:0] C_ILL  = 4'd0;
  localparam logic [3:0] C_TR   = 4'd1;
  localparam logic [3:0] C_BR   = 4'd2;
  localparam logic [3:0] C_CMP  = 4'd3;
  localparam logic [3:0] C_ALU  = 4'd4;
  localparam logic [3:0] C_MOV  = 4'd5;
  localparam logic [3:0] C_LD   = 4'd6;
  localparam logic [3:0] C_ST   = 4'd7;
  localparam logic [3:0] C_PUSH = 4'd8;
  localparam logic [3:0] C_POP  = 4'd9;
  localparam logic [3:0] C_HALT = 4'd10;

  logic [2:0]      state_q, state_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [RSW-1:0]  ra_q, ra_d;
  logic [1:0]      stk_q, stk_d;
  logic [IMMW-1:0] imm_q, imm_d;
  logic [3:0]      cls_q, cls_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            alu_q, alu_d, fwe_q, fwe_d, mov_q, mov_d, tr_q, tr_d;
  logic            pcl_q, pcl_d, ill_q, ill_d, merr_q, merr_d, acc_q, acc_d;
  logic [NREG-1:0] sel_q, sel_d;
  logic            taken;
  logic [NREG-1:0] mem_sel;
  logic            stk_acc, stk_pc;

  function automatic logic [NREG-1:0] onehot(input logic [RSW-1:0] idx);
    logic [NREG-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < NREG; i++) oh[i] = (idx == RSW'(i));
    return oh;
  endfunction

  function automatic logic [3:0] classify(input logic [OPW-1:0] op);
    logic [3:0] c;
    if (op == '1) c = C_HALT;
    else begin
      case (32'(op))
        0, 1:            c = C_TR;
        2:               c = C_LD;
        3:               c = C_ST;
        4:               c = C_PUSH;
        5:               c = C_POP;
        6, 7, 8, 9, 10:  c = C_BR;
        20:              c = C_CMP;
        21, 22:          c = C_ALU;
        23:              c = C_MOV;
        default:         c = C_ILL;
      endcase
    end
    return c;
  endfunction

  // Branch condition: opcodes 6..9 test Z,N,C,V; opcode 10 is unconditional.
  always_comb begin
    case (op_q[3:0])
      4'd6:    taken = bus.flags[3];
      4'd7:    taken = bus.flags[2];
      4'd8:    taken = bus.flags[1];
      4'd9:    taken = bus.flags[0];
      default: taken = 1'b1;
    endcase
  end

  // Next-state, field latching, EXEC strobe generation and MEM timeout.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ra_d    = ra_q;
    stk_d   = stk_q;
    imm_d   = imm_q;
    cls_d   = cls_q;
    cnt_d   = cnt_q;
    alu_d   = 1'b0;
    fwe_d   = 1'b0;
    mov_d   = 1'b0;
    tr_d    = 1'b0;
    pcl_d   = 1'b0;
    ill_d   = 1'b0;
    merr_d  = 1'b0;
    acc_d   = 1'b0;
    sel_d   = '0;
    case (state_q)
      S_FETCH: begin
        if (bus.instr_valid) begin
          op_d    = bus.opcode;
          ra_d    = bus.ra;
          stk_d   = bus.ra_stack;
          imm_d   = bus.imm;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        cls_d   = classify(op_q);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (cls_q)
          C_TR:   begin tr_d = 1'b1; sel_d = onehot(RSW'(op_q[0])); end
          C_BR:   pcl_d = taken;
          C_CMP:  begin alu_d = 1'b1; fwe_d = 1'b1; end
          C_ALU: begin
            alu_d = 1'b1;
            fwe_d = 1'b1;
            if (imm_q == '0) acc_d = 1'b1;
            else             sel_d = onehot(ra_q);
          end
          C_MOV:  begin mov_d = 1'b1; sel_d = onehot(ra_q); end
          C_LD, C_ST, C_PUSH, C_POP: begin
            state_d = S_MEM;
            cnt_d   = '0;
          end
          C_HALT: state_d = S_HALT;
          default: ill_d = 1'b1;
        endcase
      end
      S_MEM: begin
        if (bus.mem_ack) begin
          state_d = S_WB;
          cnt_d   = '0;
        end else if (cnt_q == 8'(TMO - 1)) begin
          // This is the TMO-th cycle without ack: abandon and skip WB.
          state_d = S_FETCH;
          merr_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // State, latched fields and registered strobes; reset aborts immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      ra_q    <= '0;
      stk_q   <= '0;
      imm_q   <= '0;
      cls_q   <= C_ILL;
      cnt_q   <= '0;
      alu_q   <= 1'b0;
      fwe_q   <= 1'b0;
      mov_q   <= 1'b0;
      tr_q    <= 1'b0;
      pcl_q   <= 1'b0;
      ill_q   <= 1'b0;
      merr_q  <= 1'b0;
      acc_q   <= 1'b0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      stk_q   <= stk_d;
      imm_q   <= imm_d;
      cls_q   <= cls_d;
      cnt_q   <= cnt_d;
      alu_q   <= alu_d;
      fwe_q   <= fwe_d;
      mov_q   <= mov_d;
      tr_q    <= tr_d;
      pcl_q   <= pcl_d;
      ill_q   <= ill_d;
      merr_q  <= merr_d;
      acc_q   <= acc_d;
      sel_q   <= sel_d;
    end
  end

  // Register/accumulator/PC selection while a memory access is in flight.
  always_comb begin
    mem_sel = '0;
    stk_acc = 1'b0;
    stk_pc  = 1'b0;
    if (state_q == S_MEM) begin
      if (cls_q == C_PUSH || cls_q == C_POP) begin
        case (stk_q)
          2'd0:    mem_sel[0]   = 1'b1;
          2'd1:    mem_sel[SP1] = 1'b1;
          2'd2:    stk_acc      = 1'b1;
          default: stk_pc       = 1'b1;
        endcase
      end else begin
        mem_sel = onehot(ra_q);
      end
    end
  end

  assign bus.instr_ready = (state_q == S_FETCH);
  assign bus.busy        = (state_q != S_FETCH) && (state_q != S_HALT);
  assign bus.halted      = (state_q == S_HALT);
  assign bus.mem_req     = (state_q == S_MEM);
  assign bus.mem_we      = (state_q == S_MEM) && (cls_q == C_ST || cls_q == C_PUSH);
  assign bus.sp_dec      = (state_q == S_WB) && (cls_q == C_PUSH);
  assign bus.sp_inc      = (state_q == S_WB) && (cls_q == C_POP);
  assign bus.alu_en      = alu_q;
  assign bus.flag_we     = fwe_q;
  assign bus.mov_en      = mov_q;
  assign bus.tr_en       = tr_q;
  assign bus.pc_load     = pcl_q;
  assign bus.illegal     = ill_q;
  assign bus.mem_err     = merr_q;
  assign bus.reg_sel     = sel_q | mem_sel;
  assign bus.acc_sel     = acc_q | stk_acc;
  assign bus.pc_sel      = stk_pc;
endmodule
